// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU sequencer and its users.
//                Holds the 4-bit ALU select encoding, the default datapath
//                width and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // ALU select encoding; ALU_NOP makes the ALU hold its Z register.
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;
    localparam logic [3:0] ALU_NEG = 4'b1000;
    localparam logic [3:0] ALU_NOT = 4'b1010;
    localparam logic [3:0] ALU_SHL = 4'b1100;
    localparam logic [3:0] ALU_SHR = 4'b1101;
    localparam logic [3:0] ALU_ROL = 4'b1110;
    localparam logic [3:0] ALU_ROR = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_HI = 3'd4
    } seq_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Request / response channels of the ALU sequencer.
//                Request : req_valid, req_ready, req_op, req_a, req_b
//                Response: rsp_valid, rsp_ready, rsp_data, rsp_hi,
//                          rsp_last, rsp_err
//                slave  modport = sequencer side
//                master modport = control-unit side
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) ();

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_hi;
    logic             rsp_last;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hi, rsp_last, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hi, rsp_last, rsp_err
    );

endinterface : alu_sequencer_if
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational classification of an ALU select code.
//                op       in  4  ALU select encoding
//                is_legal out 1  op names a real ALU operation
//                is_wide  out 1  op yields a full 64-bit {Hi, Lo} result
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_legal,
    output logic       is_wide
);

    always_comb begin
        is_legal = 1'b0;
        is_wide  = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NEG, ALU_NOT,
            ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR: begin
                is_legal = 1'b1;
            end
            ALU_MUL, ALU_DIV: begin
                is_legal = 1'b1;
                is_wide  = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
                is_wide  = 1'b0;
            end
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Runs one ALU operation per request: drives select/A/B for a
//                single cycle, captures the registered Z result and returns
//                it as one (Lo) or two (Lo then Hi) response beats.
//                clk        in   system clock, rising edge
//                clear      in   asynchronous active-low reset
//                bus        slave request/response channels
//                alu_select out  ALU select (ALU_NOP outside ISSUE)
//                alu_a/b    out  ALU operands, hold last driven value
//                alu_z      in   ALU result {Hi, Lo}
//                busy       out  high in every state except IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clear,
    alu_sequencer_if.slave     bus,
    output logic [3:0]         alu_select,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [2*WIDTH-1:0] alu_z,
    output logic               busy
);

    seq_state_e         r_state;
    logic [3:0]         r_alu_select;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2*WIDTH-1:0] r_z;
    logic               r_wide;
    logic               r_rsp_valid;
    logic               r_rsp_hi;
    logic               r_rsp_last;
    logic               r_rsp_err;

    logic               w_is_legal;
    logic               w_is_wide;

    alu_op_decode u_decode (
        .op       (bus.req_op),
        .is_legal (w_is_legal),
        .is_wide  (w_is_wide)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state      <= ST_IDLE;
            r_alu_select <= ALU_NOP;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_z          <= '0;
            r_wide       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hi     <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_wide <= w_is_wide;
                        if (w_is_legal) begin
                            // Select is registered, so it is live for
                            // exactly the ISSUE cycle.
                            r_state      <= ST_ISSUE;
                            r_alu_select <= bus.req_op;
                            r_alu_a      <= bus.req_a;
                            r_alu_b      <= bus.req_b;
                        end else begin
                            // Illegal op bypasses the ALU; zeroing z_q makes
                            // the error beat carry zero data.
                            r_state     <= ST_SEND_LO;
                            r_z         <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_hi    <= 1'b0;
                            r_rsp_last  <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // ALU registers Z on this closing edge; select back to hold.
                    r_alu_select <= ALU_NOP;
                    r_state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_z         <= alu_z;
                    r_state     <= ST_SEND_LO;
                    r_rsp_valid <= 1'b1;
                    r_rsp_hi    <= 1'b0;
                    r_rsp_last  <= !r_wide;
                    r_rsp_err   <= 1'b0;
                end
                ST_SEND_LO: begin
                    if (bus.rsp_ready) begin
                        if (r_wide) begin
                            r_state    <= ST_SEND_HI;
                            r_rsp_hi   <= 1'b1;
                            r_rsp_last <= 1'b1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_rsp_valid <= 1'b0;
                            r_rsp_last  <= 1'b0;
                            r_rsp_err   <= 1'b0;
                        end
                    end
                end
                ST_SEND_HI: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_hi    <= 1'b0;
                        r_rsp_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_alu_select <= ALU_NOP;
                    r_rsp_valid  <= 1'b0;
                    r_rsp_hi     <= 1'b0;
                    r_rsp_last   <= 1'b0;
                    r_rsp_err    <= 1'b0;
                end
            endcase
        end
    end

    // Payload comes straight from z_q, so it cannot change while a beat
    // is stalled.
    assign bus.rsp_data  = r_rsp_hi ? r_z[2*WIDTH-1:WIDTH] : r_z[WIDTH-1:0];
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hi    = r_rsp_hi;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.req_ready = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign alu_select    = r_alu_select;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a behavioural
//                registered ALU and a queue of expected response beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         hi;
        logic         last;
        logic         err;
    } beat_t;

    logic             clk   = 1'b0;
    logic             clear = 1'b0;
    logic [3:0]       alu_select;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2*W-1:0]   alu_z = '0;
    logic             busy;

    int               checks     = 0;
    int               failures   = 0;
    int               sel_cycles = 0;
    logic [3:0]       sel_seen   = 4'b0000;
    beat_t            exp_q[$];

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(W)) bus ();

    alu_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .clear      (clear),
        .bus        (bus),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z      (alu_z),
        .busy       (busy)
    );

    // Behavioural ALU: registers Z whenever select is not NOP.
    // Single-word ops leave a marker in Hi so a stray Hi beat is visible.
    function automatic logic [2*W-1:0] alu_model(input logic [3:0] sel,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic signed [W-1:0]   q;
        logic signed [W-1:0]   r;
        logic [2*W-1:0]        z;
        p = '0;
        q = '0;
        r = '0;
        z = {32'hDEAD_BEEF, 32'h0000_0000};
        case (sel)
            ALU_ADD: z[W-1:0] = a + b;
            ALU_SUB: z[W-1:0] = a - b;
            ALU_MUL: begin
                p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                z = p;
            end
            ALU_DIV: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                z = {r, q};
            end
            ALU_AND: z[W-1:0] = a & b;
            ALU_OR:  z[W-1:0] = a | b;
            ALU_NEG: z[W-1:0] = -a;
            ALU_NOT: z[W-1:0] = ~a;
            ALU_SHL: z[W-1:0] = a << b[4:0];
            ALU_SHR: z[W-1:0] = a >> b[4:0];
            ALU_ROL: z[W-1:0] = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
            ALU_ROR: z[W-1:0] = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
            default: z = z;
        endcase
        return z;
    endfunction

    always @(posedge clk) begin
        if (alu_select != ALU_NOP)
            alu_z <= alu_model(alu_select, alu_a, alu_b);
    end

    always @(negedge clk) begin
        if (alu_select !== ALU_NOP) begin
            sel_cycles = sel_cycles + 1;
            sel_seen   = alu_select;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [W-1:0] d, input logic h,
                                 input logic l, input logic e);
        beat_t b;
        b.data = d;
        b.hi   = h;
        b.last = l;
        b.err  = e;
        exp_q.push_back(b);
    endfunction

    // Called just after a negedge with the DUT idle; returns one negedge
    // after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Latency counted in edges from (and including) the accept edge.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat = lat + 1;
        end
        chk(tag, 64'(lat), 64'(exp_lat));
    endtask

    // Checks the current beat against the scoreboard and lets it handshake.
    task automatic take_beat(input string tag);
        beat_t e;
        int    n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 20) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 64'(bus.rsp_data), 64'(e.data));
            chk({tag, "_flags"}, 64'({bus.rsp_hi, bus.rsp_last, bus.rsp_err}),
                64'({e.hi, e.last, e.err}));
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        clear         = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_rsp",       64'({bus.rsp_valid, bus.rsp_data, bus.rsp_hi,
                                  bus.rsp_last, bus.rsp_err}), 64'd0);
        chk("rst_alu_sel",   64'(alu_select),    64'd0);
        chk("rst_alu_ab",    {alu_a, alu_b},     64'd0);

        clear = 1'b1;
        @(negedge clk);

        // Add 5 + 7
        push(32'd12, 1'b0, 1'b1, 1'b0);
        issue(ALU_ADD, 32'd5, 32'd7);
        chk("add_sel",  64'(alu_select), 64'(ALU_ADD));
        chk("add_busy", 64'({busy, bus.req_ready}), 64'b10);
        wait_valid("add_lat", 3);
        take_beat("add");
        chk("turnaround_ready", 64'(bus.req_ready), 64'd1);

        // Wide multiply, ready held high: Lo then Hi back to back
        push(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        push(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_valid("mul_lat", 3);
        take_beat("mul_lo");
        chk("mul_hi_b2b", 64'(bus.rsp_valid), 64'd1);
        take_beat("mul_hi");

        // Rotate left: select must pulse for exactly one cycle
        sel_cycles = 0;
        push(32'h0000_0003, 1'b0, 1'b1, 1'b0);
        issue(ALU_ROL, 32'h8000_0001, 32'd1);
        wait_valid("rol_lat", 3);
        take_beat("rol");
        chk("rol_sel_cycles", 64'(sel_cycles), 64'd1);
        chk("rol_sel_value",  64'(sel_seen),   64'(ALU_ROL));

        // Illegal op: immediate error beat, ALU untouched
        sel_cycles = 0;
        push(32'h0000_0000, 1'b0, 1'b1, 1'b1);
        issue(4'b0100, 32'h1234_5678, 32'h9abc_def0);
        wait_valid("ill_lat", 1);
        take_beat("ill");
        @(negedge clk);
        chk("ill_sel_cycles", 64'(sel_cycles), 64'd0);
        chk("ill_alu_a_hold", 64'(alu_a), 64'h8000_0001);

        // Subtract, signed result
        push(32'hFFFF_FFF9, 1'b0, 1'b1, 1'b0);
        issue(ALU_SUB, 32'd3, 32'd10);
        wait_valid("sub_lat", 3);
        take_beat("sub");

        // Signed divide: Lo = quotient, Hi = remainder
        push(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        push(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_valid("div_lat", 3);
        take_beat("div_lo");
        take_beat("div_hi");

        // Backpressure on the Lo beat of a multiply (-1 * 2)
        bus.rsp_ready = 1'b0;
        push(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        push(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_valid("bp_lat", 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 64'({bus.rsp_valid, bus.rsp_data, bus.rsp_hi,
                                bus.rsp_last, bus.rsp_err, bus.req_ready}),
                64'({1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0}));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        take_beat("bp_lo");
        take_beat("bp_hi");

        // Asynchronous reset while the Hi beat is pending
        push(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        push(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_valid("rst_mul_lat", 3);
        take_beat("rst_mul_lo");
        bus.rsp_ready = 1'b0;
        chk("rst_in_send_hi", 64'({bus.rsp_valid, bus.rsp_hi}), 64'b11);
        #2 clear = 1'b0;
        #1;
        chk("arst_ctrl", 64'({bus.req_ready, busy}), 64'b10);
        chk("arst_rsp",  64'({bus.rsp_valid, bus.rsp_data, bus.rsp_hi,
                              bus.rsp_last, bus.rsp_err}), 64'd0);
        chk("arst_alu",  64'({alu_select, alu_a, alu_b}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_valid", 64'(bus.rsp_valid), 64'd0);
        clear = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'({bus.req_ready, bus.rsp_valid}), 64'b10);

        // Fresh add after reset: 100 + (-1)
        bus.rsp_ready = 1'b1;
        push(32'd99, 1'b0, 1'b1, 1'b0);
        issue(ALU_ADD, 32'd100, 32'hFFFF_FFFF);
        wait_valid("post_add_lat", 3);
        take_beat("post_add");
        @(negedge clk);
        chk("no_extra_beat", 64'({bus.rsp_valid, busy}), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side controller for the datapath ALU. Accepts one operation request at a time over a valid/ready handshake and drives the ALU's `select`, `A` and `B` inputs for exactly one clock. It then captures the registered 64-bit `Z` result and returns it as one or two 32-bit beats on a valid/ready response channel. It sits between the control unit and the ALU and replaces ad-hoc select/Z-register strobing with a single sequenced transaction.

## Interface
- `WIDTH`, 32, operand and response word width; `Z` is 2*WIDTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset; asserted when 0.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request (IDLE only).
- `req_op`  in  4  ALU operation code, ALU `select` encoding.
- `req_a`  in  WIDTH  operand A (signed).
- `req_b`  in  WIDTH  operand B (signed).
- `alu_select`  out  4  to ALU `select`.
- `alu_a`  out  WIDTH  to ALU `A`.
- `alu_b`  out  WIDTH  to ALU `B`.
- `alu_z`  in  2*WIDTH  from ALU `Z`; `{Hi, Lo}`.
- `rsp_valid`  out  1  response beat present.
- `rsp_ready`  in  1  consumer accepts beat.
- `rsp_data`  out  WIDTH  beat payload.
- `rsp_hi`  out  1  1 = beat carries the Hi word.
- `rsp_last`  out  1  final beat of the transaction.
- `rsp_err`  out  1  request op was illegal; `rsp_data` = 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Legal ops: 0001 add, 0010 sub, 0011 mul, 0101 div/mod, 0110 and, 0111 or, 1000 neg, 1010 not, 1100 shl, 1101 shr, 1110 rol, 1111 ror. Illegal: 0000, 0100, 1001, 1011.
- Wide ops (two beats): 0011 and 0101. All other legal ops return one beat, Lo only.
- States: IDLE, ISSUE, CAPTURE, SEND_LO, SEND_HI.
- IDLE: `req_ready`=1. On `req_valid`: latch op/A/B. Legal op -> ISSUE. Illegal op -> SEND_LO with err flag set and no ALU issue.
- ISSUE, one cycle: `alu_select`=op, `alu_a`/`alu_b` = latched operands. The ALU registers at the closing edge. -> CAPTURE.
- CAPTURE, one cycle: `alu_select`=0000 (ALU hold), sample `alu_z` into the internal 64-bit `z_q`. -> SEND_LO.
- SEND_LO: `rsp_valid`=1, `rsp_data`=`z_q[WIDTH-1:0]` (or 0 on err), `rsp_hi`=0, `rsp_last`=!wide, `rsp_err`=err. On `rsp_ready`: wide -> SEND_HI, else -> IDLE.
- SEND_HI: `rsp_valid`=1, `rsp_data`=`z_q[2*WIDTH-1:WIDTH]`, `rsp_hi`=1, `rsp_last`=1. On `rsp_ready` -> IDLE.
- Outside ISSUE, `alu_select`=0000. `alu_a` and `alu_b` hold their last driven values.
- Response payload is held stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset (`clear`=0, asynchronous) values: state IDLE, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_hi`=0, `rsp_last`=0, `rsp_err`=0, `alu_select`=0000, `alu_a`=0, `alu_b`=0, `z_q`=0.
- Latency, legal op: accept edge T -> ISSUE in T+1 -> CAPTURE in T+2 -> `rsp_valid` in T+3.
- Latency, illegal op: `rsp_valid` in T+1.
- Minimum turnaround: a one-beat response accepted at edge E allows a new accept at edge E+1.
- Requests during non-IDLE states are not accepted (`req_ready`=0). The upstream block holds the request.
- Reset mid-transaction: the transaction is abandoned and no further beats are produced. The ALU's internal Lo/Hi are not cleared by this block.
- `rsp_ready` held high: a wide response takes two consecutive cycles.

## Structure
- Shared package `alu_pkg`: 4-bit op code constants (`ALU_ADD` … `ALU_ROR`, `ALU_NOP`=0000), `WIDTH` default, and the state encoding.
- One combinational sub-module, `alu_op_decode`: `op` -> `is_legal`, `is_wide`. It is reusable by the control unit.
- The sequencer is one FSM plus the operand, op and `z_q` registers.

## Test plan
- Add: op 0001, A=5, B=7, `rsp_ready`=1 -> one beat in T+3, data 12, `rsp_last`=1, `rsp_hi`=0, `rsp_err`=0.
- Mul: op 0011, A=0x0001_0000, B=0x0001_0000 -> beat 0x0000_0000 (`rsp_hi`=0, `rsp_last`=0), then beat 0x0000_0001 (`rsp_hi`=1, `rsp_last`=1).
- Rotate: op 1110, A=0x8000_0001, B=1 -> single beat 0x0000_0003. Check that `alu_select`=1110 for exactly one cycle.
- Illegal: op 0100 -> beat in T+1 with data 0, `rsp_err`=1, `rsp_last`=1. Check that `alu_select` never leaves 0000.
- Backpressure: mul with `rsp_ready`=0 for 5 cycles in SEND_LO, then 1 -> data and flags stable throughout, `req_ready`=0, two beats delivered in order.
- Reset mid SEND_HI: drop `clear` asynchronously -> all outputs at reset values immediately. After release, `req_ready`=1, and a fresh add completes normally.
